// File: rtl/clk_rst_ctrl.sv
// clk_rst_ctrl: reset sequencer plus per-channel divided clock enables with halt/step.
// Define STARFISH_CYCLE_CNT_EN to add the 32-bit RUN/STEP cycle_cnt output.
module clk_rst_ctrl #(
    parameter int NUM_CH   = 2,
    parameter int DIV_W    = 8,
    parameter int HOLD_CYC = 16,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              halt_req,
    input  logic              step_req,
`ifdef STARFISH_CYCLE_CNT_EN
    output logic [31:0]       cycle_cnt,
`endif
    output logic              rst_out_n,
    output logic [NUM_CH-1:0] ce,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_HOLD,
        S_RUN,
        S_HALT,
        S_STEP
    } state_t;

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYC - 1);
    localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);

    state_t            r_state;
    logic [1:0]        r_sync;
    logic [7:0]        r_hold;
    logic              r_rst_out_n;
    logic              r_halted;
    logic [DIV_W-1:0]  r_div [NUM_CH];
    logic [DIV_W-1:0]  r_cnt [NUM_CH];
    logic [NUM_CH-1:0] w_match;
    logic              w_live;
    logic              w_wr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_SYNC;
            r_sync      <= 2'b00;
            r_hold      <= 8'd0;
            r_rst_out_n <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
            unique case (r_state)
                // first high sample already held, second one arriving now
                S_SYNC: begin
                    if (r_sync == 2'b01) begin
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state     <= S_RUN;
                        r_rst_out_n <= 1'b1;
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                S_RUN: begin
                    if (halt_req) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (!halt_req) begin
                        r_state  <= S_RUN;
                        r_halted <= 1'b0;
                    end else if (step_req) begin
                        r_state  <= S_STEP;
                        r_halted <= 1'b0;
                    end
                end
                S_STEP: begin
                    r_state  <= S_HALT;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state     <= S_SYNC;
                    r_rst_out_n <= 1'b0;
                    r_halted    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_match[i] = (r_cnt[i] == r_div[i]);
        end
    end

    assign w_live  = (r_state == S_RUN) || (r_state == S_HALT) ||
                     (r_state == S_STEP);
    assign w_wr_ok = cfg_we && w_live && (int'(cfg_ch) < NUM_CH);

    // a write restarts the channel phase and wins over the counter update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr_ok && (int'(cfg_ch) == i)) begin
                    r_div[i] <= cfg_div;
                    r_cnt[i] <= '0;
                end else if (r_state == S_RUN) begin
                    r_cnt[i] <= w_match[i] ? '0 : r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        ce = '0;
        if (r_state == S_RUN) begin
            ce = w_match;
        end else if (r_state == S_STEP) begin
            ce = '1;
        end
    end

    assign rst_out_n = r_rst_out_n;
    assign halted    = r_halted;

`ifdef STARFISH_CYCLE_CNT_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= 32'd0;
        end else if ((r_state == S_RUN) || (r_state == S_STEP)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`endif

endmodule
